multi_ch_timer: RTL and testbench

//   NUM_CH independent enable-gated interval timers sharing one run-time terminal count.

---
 rtl/multi_ch_timer.sv | 99 +++++++++
 tb/tb_multi_ch_timer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_ch_timer.sv
`default_nettype none
// ============================================================================
// Module   : multi_ch_timer
// Brief    : NUM_CH enable-gated interval timers (periodic / one-shot) sharing
//            one run-time loadable terminal count.
// Revision : 1.0 - initial release
// ============================================================================
module multi_ch_timer #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 8,
    parameter int DEFAULT_TC = 99
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       one_shot,
    input  logic                    tc_load,
    input  logic [CNT_W-1:0]        tc_in,
    output logic [CNT_W-1:0]        tc,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       expired,
    output logic [NUM_CH*CNT_W-1:0] cnt
);

    localparam logic [1:0]       c_IDLE    = 2'd0;
    localparam logic [1:0]       c_RUN     = 2'd1;
    localparam logic [1:0]       c_EXPIRED = 2'd2;
    localparam logic [CNT_W-1:0] c_RST_TC  = CNT_W'(DEFAULT_TC);

    logic [CNT_W-1:0] r_tc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tc <= c_RST_TC;
        end else if (tc_load) begin
            r_tc <= tc_in;
        end
    end

    assign tc = r_tc;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [1:0]       r_state;
            logic [CNT_W-1:0] r_cnt;
            logic             r_done;

            // >= rather than == so a lowered tc terminates the live count
            // instead of letting it wrap through the full counter range.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                    r_done  <= 1'b0;
                end else begin
                    case (r_state)
                        c_IDLE, c_RUN: begin
                            if (en[i]) begin
                                if (r_cnt >= r_tc) begin
                                    r_cnt   <= '0;
                                    r_done  <= 1'b1;
                                    r_state <= one_shot[i] ? c_EXPIRED : c_RUN;
                                end else begin
                                    r_cnt   <= r_cnt + 1'b1;
                                    r_done  <= 1'b0;
                                    r_state <= c_RUN;
                                end
                            end else begin
                                r_cnt   <= '0;
                                r_done  <= 1'b0;
                                r_state <= c_IDLE;
                            end
                        end
                        c_EXPIRED: begin
                            r_cnt  <= '0;
                            r_done <= 1'b0;
                            if (!en[i]) begin
                                r_state <= c_IDLE;
                            end
                        end
                        default: begin
                            r_cnt   <= '0;
                            r_done  <= 1'b0;
                            r_state <= c_IDLE;
                        end
                    endcase
                end
            end

            assign done[i]                 = r_done;
            assign busy[i]                 = (r_state == c_RUN);
            assign expired[i]              = (r_state == c_EXPIRED);
            assign cnt[i*CNT_W +: CNT_W]   = r_cnt;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_ch_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_ch_timer
// Brief    : Directed self-checking bench for multi_ch_timer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_ch_timer;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       one_shot;
    logic                    tc_load;
    logic [CNT_W-1:0]        tc_in;
    logic [CNT_W-1:0]        tc;
    logic [NUM_CH-1:0]       done;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       expired;
    logic [NUM_CH*CNT_W-1:0] cnt;

    int n_checks = 0;
    int n_errors = 0;

    multi_ch_timer #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .DEFAULT_TC (99)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .one_shot (one_shot),
        .tc_load  (tc_load),
        .tc_in    (tc_in),
        .tc       (tc),
        .done     (done),
        .busy     (busy),
        .expired  (expired),
        .cnt      (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt_of(input int ch);
        logic [NUM_CH*CNT_W-1:0] sh;
        sh = cnt >> (ch * CNT_W);
        return {24'd0, sh[CNT_W-1:0]};
    endfunction

    task automatic load_tc(input logic [CNT_W-1:0] v);
        tc_load = 1'b1;
        tc_in   = v;
        step();
        tc_load = 1'b0;
        chk("tc_loaded", {24'd0, tc}, {24'd0, v});
    endtask

    initial begin
        rst      = 1'b1;
        en       = '0;
        one_shot = '0;
        tc_load  = 1'b0;
        tc_in    = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_tc",      {24'd0, tc}, 32'd99);
        chk("rst_done",    {28'd0, done}, 32'd0);
        chk("rst_busy",    {28'd0, busy}, 32'd0);
        chk("rst_expired", {28'd0, expired}, 32'd0);
        chk("rst_cnt",     cnt, 32'd0);

        // 1: default tc=99, periodic on channel 0
        en[0] = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            step();
            chk("t1_done0", {31'd0, done[0]}, {31'd0, (k % 100) == 0});
            chk("t1_cnt0",  cnt_of(0), k % 100);
            chk("t1_busy0", {31'd0, busy[0]}, 32'd1);
        end
        en[0] = 1'b0;
        step();
        chk("t1_idle_busy", {31'd0, busy[0]}, 32'd0);

        // 2: tc=3, periodic channel 1
        load_tc(8'd3);
        en[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("t2_cnt1",  cnt_of(1), k % 4);
            chk("t2_done1", {31'd0, done[1]}, {31'd0, (k % 4) == 0});
        end
        en[1] = 1'b0;
        step();

        // 3: tc=3, one-shot channel 2, then re-arm
        one_shot[2] = 1'b1;
        en[2]       = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("t3_done2",    {31'd0, done[2]}, {31'd0, k == 4});
            chk("t3_cnt2",     cnt_of(2), (k < 4) ? k : 0);
            chk("t3_expired2", {31'd0, expired[2]}, {31'd0, k >= 4});
            chk("t3_busy2",    {31'd0, busy[2]}, {31'd0, k < 4});
        end
        en[2] = 1'b0;
        step();
        chk("t3_rearm_expired", {31'd0, expired[2]}, 32'd0);
        chk("t3_rearm_busy",    {31'd0, busy[2]}, 32'd0);
        en[2] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t3_rearm_done2", {31'd0, done[2]}, {31'd0, k == 4});
        end
        chk("t3_rearm_expired2", {31'd0, expired[2]}, 32'd1);
        en[2]       = 1'b0;
        one_shot[2] = 1'b0;
        step();

        // 4: tc lowered below the live count
        load_tc(8'd10);
        en[0] = 1'b1;
        for (int k = 1; k <= 7; k++) step();
        chk("t4_cnt0_7", cnt_of(0), 32'd7);
        tc_load = 1'b1;
        tc_in   = 8'd5;
        step();
        tc_load = 1'b0;
        chk("t4_cnt0_8",  cnt_of(0), 32'd8);
        chk("t4_tc5",     {24'd0, tc}, 32'd5);
        chk("t4_nodone",  {31'd0, done[0]}, 32'd0);
        step();
        chk("t4_done0",   {31'd0, done[0]}, 32'd1);
        chk("t4_cnt0_0",  cnt_of(0), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("t4_p6_done0", {31'd0, done[0]}, {31'd0, (k % 6) == 0});
            chk("t4_p6_cnt0",  cnt_of(0), k % 6);
        end
        en[0] = 1'b0;
        step();

        // 5: tc=0 on all channels, then reset mid-run (overrides tc_load)
        load_tc(8'd0);
        en = 4'b1111;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t5_done_all", {28'd0, done}, 32'hF);
            chk("t5_cnt_all",  cnt, 32'd0);
            chk("t5_busy_all", {28'd0, busy}, 32'hF);
        end
        rst     = 1'b1;
        tc_load = 1'b1;
        tc_in   = 8'd7;
        step();
        rst     = 1'b0;
        tc_load = 1'b0;
        en      = '0;
        chk("t5_rst_done",    {28'd0, done}, 32'd0);
        chk("t5_rst_busy",    {28'd0, busy}, 32'd0);
        chk("t5_rst_expired", {28'd0, expired}, 32'd0);
        chk("t5_rst_cnt",     cnt, 32'd0);
        chk("t5_rst_tc",      {24'd0, tc}, 32'd99);

        // 6: tc=5, partial count on channel 3 discarded
        load_tc(8'd5);
        en[3] = 1'b1;
        for (int k = 1; k <= 4; k++) step();
        chk("t6_cnt3_4", cnt_of(3), 32'd4);
        en[3] = 1'b0;
        step();
        chk("t6_abort_done", {31'd0, done[3]}, 32'd0);
        chk("t6_abort_cnt",  cnt_of(3), 32'd0);
        chk("t6_abort_busy", {31'd0, busy[3]}, 32'd0);
        en[3] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("t6_done3", {31'd0, done[3]}, {31'd0, k == 6});
            chk("t6_cnt3",  cnt_of(3), k % 6);
        end
        en[3] = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
